dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/risc_mem_pkg.sv | 33 +++
 rtl/dmem_responder_if.sv | 28 ++
 rtl/dmem_array.sv | 43 ++++
 rtl/dmem_responder.sv | 204 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/risc_mem_pkg.sv
// Shared definitions for the data-memory responder.
//   dmem_state_t   : responder FSM states (IDLE, WAIT, RESP)
//   dmem_rsp_t     : response payload (rdata, err)
//   WORD_BYTES     : bytes per memory word
//   store_be_legal : store byte-enable / address alignment rule
package risc_mem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } dmem_rsp_t;

  // A store is legal for an empty mask, any single byte, a half-word on an
  // even address, or a full word on a word-aligned address.
  function automatic logic store_be_legal(input logic [WORD_BYTES-1:0] be,
                                          input logic [1:0]            lo);
    case (be)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
      4'b0011, 4'b1100:                            return (lo[0] == 1'b0);
      4'b1111:                                     return (lo == 2'b00);
      default:                                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a core and the data-memory responder.
//   master modport : core side (drives request and rsp_ready)
//   slave modport  : responder side (drives req_ready and the response)
interface dmem_responder_if;
  import risc_mem_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [31:0]           req_addr;
  logic [WORD_BYTES-1:0] req_be;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32-bit data storage, one byte-wide RAM per lane.
//   clk   : clock
//   we    : write strobe, qualified per lane by be
//   be    : byte enables, bit i covers wdata[8i+7:8i]
//   waddr : write word index
//   wdata : write data
//   re    : read strobe; rdata holds its value while re is low
//   raddr : read word index
//   rdata : registered read data (old contents on a same-edge write)
module dmem_array
  import risc_mem_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [WORD_BYTES-1:0]      be,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [31:0]                wdata,
  input  logic                       re,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [31:0]                rdata
);

  generate
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
        if (we && be[gi]) begin
          mem[waddr] <= wdata[gi*8 +: 8];
        end
        if (re) begin
          rd_q <= mem[raddr];
        end
      end

      assign rdata[gi*8 +: 8] = rd_q;
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts WAIT_CYC
// wait states, then presents a response held until the core takes it.
//   clk    : clock, rising edge
//   srst_n : asynchronous active-low reset (aborts any in-flight access;
//            memory contents are kept)
//   bus    : dmem_responder_if.slave request/response channel
// Parameters: DEPTH (words, power of 2, >= 4), WAIT_CYC (0..15).
// Build option: define DMEM_RANGE_CHECK_EN to fault addresses beyond DEPTH
// words; otherwise upper address bits are ignored and addresses wrap.
module dmem_responder
  import risc_mem_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int WAIT_CYC = 1
) (
  input  logic                   clk,
  input  logic                   srst_n,
  dmem_responder_if.slave        bus
);

  localparam int AW  = $clog2(DEPTH);
  localparam int OFF = $clog2(WORD_BYTES);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  dmem_state_t           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  load_ok_q, load_ok_d;   // response carries array data
  logic                  we_q, we_d;
  logic [WORD_BYTES-1:0] be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic                  fault_q, fault_d;

  logic                  accept;
  logic                  enter_resp;
  logic                  in_idle;
  logic                  req_misalign;
  logic                  req_oor;
  logic                  req_fault;
  logic                  cur_we;
  logic                  cur_fault;
  logic [WORD_BYTES-1:0] cur_be;
  logic [31:0]           cur_wdata;
  logic [AW-1:0]         cur_idx;
  logic                  arr_we;
  logic                  arr_re;
  logic [31:0]           arr_rdata;
  dmem_rsp_t             rsp;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^bus.req_addr[31:AW+OFF];

  // Request checks on the incoming (not yet registered) request.
  always_comb begin
    req_misalign = bus.req_we ? !store_be_legal(bus.req_be, bus.req_addr[1:0])
                              : (bus.req_addr[1:0] != 2'b00);
`ifdef DMEM_RANGE_CHECK_EN
    req_oor = (bus.req_addr >> (AW + OFF)) != '0;
`else
    req_oor = 1'b0;
`endif
    req_fault = req_misalign || req_oor;
  end

  assign in_idle = (state_q == IDLE);
  assign accept  = in_idle && req_ready_q && bus.req_valid;

  // With WAIT_CYC=0 the commit edge is the accept edge, so the array must
  // see the live request; otherwise it sees the registered copy.
  assign cur_we    = in_idle ? bus.req_we    : we_q;
  assign cur_be    = in_idle ? bus.req_be    : be_q;
  assign cur_wdata = in_idle ? bus.req_wdata : wdata_q;
  assign cur_idx   = in_idle ? bus.req_addr[AW+OFF-1:OFF] : idx_q;
  assign cur_fault = in_idle ? req_fault     : fault_q;

  assign enter_resp = (accept && (WAIT_CYC == 0)) ||
                      ((state_q == WAIT) && (cnt_q == 4'd0));

  // Stores commit and loads sample the array on the edge that enters RESP.
  assign arr_we = enter_resp && cur_we && !cur_fault;
  assign arr_re = enter_resp && !cur_we;

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (cur_be),
    .waddr (cur_idx),
    .wdata (cur_wdata),
    .re    (arr_re),
    .raddr (cur_idx),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    load_ok_d   = load_ok_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    idx_d       = idx_q;
    fault_d     = fault_q;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          req_ready_d = 1'b0;
          we_d        = bus.req_we;
          be_d        = bus.req_be;
          wdata_d     = bus.req_wdata;
          idx_d       = bus.req_addr[AW+OFF-1:OFF];
          fault_d     = req_fault;
          if (WAIT_CYC == 0) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_fault;
            load_ok_d   = !bus.req_we && !req_fault;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = fault_q;
          load_ok_d   = !we_q && !fault_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // req_ready stays low through the handshake edge, so the next
        // accept can happen no earlier than the following edge.
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          load_ok_d   = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        load_ok_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      load_ok_q   <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      idx_q       <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      load_ok_q   <= load_ok_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      fault_q     <= fault_d;
    end
  end

  // Array read register holds while in RESP (no new read strobe), so gating
  // it with a registered flag keeps rdata stable and zero for stores/faults.
  always_comb begin
    rsp.rdata = load_ok_q ? arr_rdata : 32'h0;
    rsp.err   = rsp_err_q;
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp.rdata;
  assign bus.rsp_err   = rsp.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH=1024, WAIT_CYC=1).
module tb_dmem_responder;

  localparam int DEPTH    = 1024;
  localparam int WAIT_CYC = 1;
  localparam int LAT      = WAIT_CYC + 1;

  logic clk    = 1'b0;
  logic srst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dmem_responder_if bus();

  dmem_responder #(
    .DEPTH    (DEPTH),
    .WAIT_CYC (WAIT_CYC)
  ) dut (
    .clk    (clk),
    .srst_n (srst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_be    = 4'h0;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
  endtask

  // Presents a request once req_ready is seen; returns at the negedge after
  // the accept edge (first cycle after accept).
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_wait: req_ready=%b required 1", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_be    = be;
    bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wdata = 32'hFFFF_FFFF;
  endtask

  // Counts cycles after the accept edge until rsp_valid (bounded).
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er,
                     output int lat);
    issue(we, addr, be, wd);
    wait_rsp(lat);
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    finish_rsp();
  endtask

  task automatic test_reset();
    drive_idle();
    srst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks += 4;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", bus.req_ready); end
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
    if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata: got %h want 0", bus.rsp_rdata); end
    if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b want 0", bus.rsp_err); end
    srst_n = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_release_ready_early: got %b want 0", bus.req_ready); end
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", bus.req_ready); end
    $display("test_reset done");
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, er, lat);
    checks += 3;
    if (lat != LAT) begin errors++; $display("FAIL store_latency: got %0d want %0d", lat, LAT); end
    if (er !== 1'b0) begin errors++; $display("FAIL store_err: got %b want 0", er); end
    if (rd !== 32'h0) begin errors++; $display("FAIL store_rdata: got %h want 0", rd); end
    $display("store 0x10 be=f wd=deadbeef -> err=%b rd=%h lat=%0d", er, rd, lat);
    txn(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat);
    checks += 3;
    if (lat != LAT) begin errors++; $display("FAIL load_latency: got %0d want %0d", lat, LAT); end
    if (er !== 1'b0) begin errors++; $display("FAIL load_err: got %b want 0", er); end
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata: got %h want deadbeef", rd); end
    $display("load 0x10 -> err=%b rd=%h lat=%0d", er, rd, lat);
  endtask

  task automatic test_byte_store();
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 32'h10, 4'hF, 32'h11223344, rd, er, lat);
    txn(1'b1, 32'h12, 4'b0100, 32'h00AB0000, rd, er, lat);
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL byte_store_err: got %b want 0", er); end
    txn(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h11AB3344) begin errors++; $display("FAIL byte_store_rdata: got %h want 11ab3344", rd); end
    $display("byte store 0x12 be=4 -> load 0x10 rd=%h", rd);
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic er; int lat;
    txn(1'b0, 32'h13, 4'h0, 32'h0, rd, er, lat);
    checks += 2;
    if (er !== 1'b1) begin errors++; $display("FAIL mis_load_err: got %b want 1", er); end
    if (rd !== 32'h0) begin errors++; $display("FAIL mis_load_rdata: got %h want 0", rd); end
    $display("load 0x13 -> err=%b rd=%h", er, rd);
    txn(1'b1, 32'h12, 4'hF, 32'hFFFFFFFF, rd, er, lat);
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL mis_store_word_err: got %b want 1", er); end
    txn(1'b1, 32'h11, 4'b0011, 32'hFFFFFFFF, rd, er, lat);
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL mis_store_half_err: got %b want 1", er); end
    txn(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, rd, er, lat);
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL empty_be_err: got %b want 0", er); end
    txn(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h11AB3344) begin errors++; $display("FAIL mis_unchanged: got %h want 11ab3344", rd); end
    $display("after faulted/empty stores load 0x10 rd=%h", rd);
    txn(1'b1, 32'h12, 4'b1100, 32'h55660000, rd, er, lat);
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL half_store_err: got %b want 0", er); end
    txn(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h55663344) begin errors++; $display("FAIL half_store_rdata: got %h want 55663344", rd); end
    $display("half store 0x12 be=c -> load 0x10 rd=%h", rd);
  endtask

  task automatic test_backpressure();
    int lat;
    issue(1'b0, 32'h10, 4'h0, 32'h0);
    wait_rsp(lat);
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL bp_latency: got %0d want %0d", lat, LAT); end
    for (int i = 0; i < 5; i++) begin
      checks += 4;
      if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.rsp_valid); end
      if (bus.rsp_rdata !== 32'h55663344) begin errors++; $display("FAIL bp_rdata[%0d]: got %h want 55663344", i, bus.rsp_rdata); end
      if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL bp_err[%0d]: got %b want 0", i, bus.rsp_err); end
      if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, bus.req_ready); end
      @(negedge clk);
    end
    finish_rsp();
    checks += 2;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", bus.rsp_valid); end
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_idle: got %b want 1", bus.req_ready); end
    $display("backpressure 5 cycles -> released, req_ready=%b", bus.req_ready);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; int lat;
    issue(1'b1, 32'h30, 4'hF, 32'h0BADCAFE);
    wait_rsp(lat);
    // Next request already waiting during the response handshake cycle.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h30;
    bus.req_be    = 4'h0;
    bus.rsp_ready = 1'b1;
    checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_hs: got %b want 0", bus.req_ready); end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checks += 2;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_after_hs: got %b want 0", bus.rsp_valid); end
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_not_accepted_at_hs: got %b want 1", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_accepted_next: got %b want 0", bus.req_ready); end
    wait_rsp(lat);
    rd = bus.rsp_rdata;
    finish_rsp();
    checks += 2;
    if (lat != LAT) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); end
    if (rd !== 32'h0BADCAFE) begin errors++; $display("FAIL b2b_rdata: got %h want 0badcafe", rd); end
    $display("back-to-back store/load 0x30 -> rd=%h lat=%0d", rd, lat);
  endtask

  task automatic test_range();
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 32'h0, 4'hF, 32'hAAAA5555, rd, er, lat);
    txn(1'b0, 32'h1000, 4'h0, 32'h0, rd, er, lat);
    checks += 2;
`ifdef DMEM_RANGE_CHECK_EN
    if (er !== 1'b1) begin errors++; $display("FAIL range_load_err: got %b want 1", er); end
    if (rd !== 32'h0) begin errors++; $display("FAIL range_load_rdata: got %h want 0", rd); end
`else
    if (er !== 1'b0) begin errors++; $display("FAIL range_load_err: got %b want 0", er); end
    if (rd !== 32'hAAAA5555) begin errors++; $display("FAIL range_load_alias: got %h want aaaa5555", rd); end
`endif
    $display("load 0x1000 -> err=%b rd=%h", er, rd);
    txn(1'b1, 32'h1000, 4'hF, 32'h12345678, rd, er, lat);
    txn(1'b0, 32'h0, 4'h0, 32'h0, rd, er, lat);
    checks++;
`ifdef DMEM_RANGE_CHECK_EN
    if (rd !== 32'hAAAA5555) begin errors++; $display("FAIL range_store_blocked: got %h want aaaa5555", rd); end
`else
    if (rd !== 32'h12345678) begin errors++; $display("FAIL range_store_alias: got %h want 12345678", rd); end
`endif
    $display("store 0x1000 then load 0x0 -> rd=%h", rd);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 32'h20, 4'hF, 32'h01020304, rd, er, lat);
    issue(1'b1, 32'h20, 4'hF, 32'hCAFEF00D);
    srst_n = 1'b0;
    #1;
    checks += 2;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_valid: got %b want 0", bus.rsp_valid); end
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_wait_ready: got %b want 0", bus.req_ready); end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_valid_held: got %b want 0", bus.rsp_valid); end
    srst_n = 1'b1;
    txn(1'b0, 32'h20, 4'h0, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h01020304) begin errors++; $display("FAIL rst_store_aborted: got %h want 01020304", rd); end
    $display("reset during store WAIT -> load 0x20 rd=%h", rd);
    issue(1'b0, 32'h20, 4'h0, 32'h0);
    wait_rsp(lat);
    srst_n = 1'b0;
    #1;
    checks += 3;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", bus.rsp_valid); end
    if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata: got %h want 0", bus.rsp_rdata); end
    if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err: got %b want 0", bus.rsp_err); end
    @(negedge clk);
    srst_n = 1'b1;
    txn(1'b0, 32'h20, 4'h0, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h01020304) begin errors++; $display("FAIL rst_mem_kept: got %h want 01020304", rd); end
    $display("reset during load RESP -> load 0x20 rd=%h", rd);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_store();
    test_misaligned();
    test_backpressure();
    test_back_to_back();
    test_range();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
